// File: rtl/dmem_bridge.sv
// dmem_bridge: load/store bridge from the core to a split address/data SRAM bus.
// Aligns byte/half lanes, stalls the core while busy, flags misalignment and address timeouts.
module dmem_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;
    state_e      state_q;
    logic        we_q, uns_q, rdata_valid_q, addr_err_q, bus_err_q;
    logic [1:0]  size_q;
    logic [3:0]  be_q, be_d;
    logic [7:0]  cnt_q, cnt_d, byte_l;
    logic [15:0] half_l;
    logic [31:0] addr_q, wdata_q, wdata_d, rdata_q, load_d;
    logic        is_half, is_word, misaligned;
    always_comb begin
        is_half    = req_size == 2'd1;
        is_word    = req_size[1];
        misaligned = (is_half & req_addr[0]) | (is_word & |req_addr[1:0]);
        be_d       = is_word ? 4'hF : is_half ? (req_addr[1] ? 4'hC : 4'h3) : 4'h1 << req_addr[1:0];
        wdata_d    = is_word ? req_wdata : is_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
        byte_l     = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_l     = bus_rdata[{addr_q[1], 4'b0000} +: 16];
        load_d     = size_q[1] ? bus_rdata
                   : size_q[0] ? {{16{~uns_q & half_l[15]}}, half_l}
                   : {{24{~uns_q & byte_l[7]}}, byte_l};
        cnt_d      = cnt_q + 8'd1;
        stall      = (state_q == IDLE & req_valid & ~misaligned) | state_q == ADDR | state_q == DATA;
    end
    assign bus_req     = state_q == ADDR;
    assign bus_wr      = we_q;
    assign bus_be      = be_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign addr_err    = addr_err_q;
    assign bus_err     = bus_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= 2'd0;
            be_q          <= 4'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            rdata_q       <= 32'd0;
            cnt_q         <= 8'd0;
            rdata_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    if (misaligned) addr_err_q <= 1'b1;
                    else begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        be_q    <= be_d;
                        addr_q  <= req_addr;
                        wdata_q <= wdata_d;
                        cnt_q   <= 8'd0;
                        state_q <= ADDR;
                    end
                end
                ADDR: if (bus_addr_ok) begin
                    state_q <= bus_data_ok ? DONE : DATA;
                    if (bus_data_ok & ~we_q) begin
                        rdata_q       <= load_d;
                        rdata_valid_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_d;
                    // abort the access once the address phase has waited TIMEOUT cycles
                    if (cnt_d == 8'(TIMEOUT)) begin
                        state_q   <= DONE;
                        bus_err_q <= 1'b1;
                        rdata_q   <= 32'd0;
                    end
                end
                DATA: if (bus_data_ok) begin
                    state_q <= DONE;
                    if (~we_q) begin
                        rdata_q       <= load_d;
                        rdata_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: random and directed load/store transactions checked against a behavioural model.
module tb_dmem_bridge;
    localparam int TO = 16;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        stall, rdata_valid, addr_err, bus_err, bus_req, bus_wr;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    int          n_pass = 0, n_chk = 0;
    logic [31:0] model_rdata = 32'd0;

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .addr_err(addr_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Runs one request from an IDLE cycle (entered at posedge+1) back to the next IDLE cycle.
    // adly: extra ADDR cycles before addr_ok (>= TO means never); ddly: cycles after addr_ok until data_ok.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rw, input int adly, input int ddly);
        bit mis, tmo;
        logic [31:0] sh, exp_ld, exp_wd;
        logic [3:0] exp_be;
        int n_addr;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
        tmo = adly >= TO;
        sh = rw >> (8 * a[1:0]);
        if (sz >= 2'd2) begin
            exp_ld = rw; exp_be = 4'hF; exp_wd = wd;
        end else if (sz == 2'd1) begin
            exp_ld = (!uns && sh[15]) ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
            exp_be = 4'h3 << a[1:0]; exp_wd = (wd & 32'hFFFF) * 32'h00010001;
        end else begin
            exp_ld = (!uns && sh[7]) ? (sh | 32'hFFFFFF00) : (sh & 32'h000000FF);
            exp_be = 4'h1 << a[1:0]; exp_wd = (wd & 32'hFF) * 32'h01010101;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(negedge clk);
        check("stall_on_req", 32'(stall), 32'(!mis));
        @(posedge clk); #1;
        if (mis) begin
            req_valid = 1'b0;
            @(negedge clk);
            check("addr_err", 32'(addr_err), 32'd1);
            check("mis_bus_req", 32'(bus_req), 32'd0);
            check("mis_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            return;
        end
        n_addr = tmo ? TO : adly + 1;
        for (int c = 0; c < n_addr; c++) begin
            bus_addr_ok = !tmo && c == adly;
            bus_data_ok = bus_addr_ok && ddly == 0;
            bus_rdata = bus_data_ok ? rw : $urandom;
            @(negedge clk);
            check("addr_bus_req", 32'(bus_req), 32'd1);
            check("addr_stall", 32'(stall), 32'd1);
            if (c == 0) begin
                check("bus_be", 32'(bus_be), 32'(exp_be));
                check("bus_addr", bus_addr, a);
                check("bus_wr", 32'(bus_wr), 32'(we));
                if (we) check("bus_wdata", bus_wdata, exp_wd);
            end
            @(posedge clk); #1;
        end
        bus_addr_ok = 1'b0;
        if (!tmo) for (int d = 0; d < ddly; d++) begin
            bus_data_ok = d == ddly - 1;
            bus_rdata = bus_data_ok ? rw : $urandom;
            @(negedge clk);
            check("data_bus_req", 32'(bus_req), 32'd0);
            check("data_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
        end
        bus_data_ok = 1'b0; bus_rdata = $urandom; req_valid = 1'b0;
        if (tmo) model_rdata = 32'd0;
        else if (!we) model_rdata = exp_ld;
        @(negedge clk);
        check("done_stall", 32'(stall), 32'd0);
        check("done_bus_req", 32'(bus_req), 32'd0);
        check("rdata_valid", 32'(rdata_valid), 32'(!we && !tmo));
        check("bus_err", 32'(bus_err), 32'(tmo));
        check("rdata", rdata, model_rdata);
        @(posedge clk); #1;
        check("idle_rdata_valid", 32'(rdata_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pulses", 32'({rdata_valid, addr_err, bus_err, bus_wr}), 32'd0);
        @(posedge clk); #1;
        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 2, 3);
        txn(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80112233, 1, 1);
        txn(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 32'h80112233, 0, 2);
        txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'd0, 0, 0);
        txn(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 32'd0, 0, 0);
        txn(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 32'h8001_7FFF, 0, 1);
        txn(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 32'h12345678, TO + 4, 0);
        txn(1'b0, 2'd3, 1'b0, 32'h108, 32'd0, 32'hCAFEF00D, TO - 2, 0);
        // reset in the middle of a load's data phase
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300;
        @(posedge clk); #1;
        bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
        @(negedge clk);
        check("late_data_ok_valid", 32'(rdata_valid), 32'd0);
        check("late_data_ok_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        model_rdata = 32'd0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int adly;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'd0;
            adly = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 4));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, $urandom, adly, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
